// File: rtl/i2s_frame_scheduler_if.sv
// i2s_frame_scheduler_if
// Bundles the upstream sample stream (in_left/in_right/in_valid/in_ready) and the
// transmitter-side signals (lrclk in, left_data/right_data out) of the frame scheduler.
//   slave  : scheduler side (consumes stream and lrclk, drives in_ready and frame data)
//   master : upstream/transmitter side (drives stream and lrclk)
interface i2s_frame_scheduler_if #(
  parameter int unsigned WORD_SIZE = 24
);
  logic [WORD_SIZE-1:0] in_left;
  logic [WORD_SIZE-1:0] in_right;
  logic                 in_valid;
  logic                 in_ready;
  logic                 lrclk;
  logic [WORD_SIZE-1:0] left_data;
  logic [WORD_SIZE-1:0] right_data;

  modport slave (
    input  in_left, in_right, in_valid, lrclk,
    output in_ready, left_data, right_data
  );

  modport master (
    output in_left, in_right, in_valid, lrclk,
    input  in_ready, left_data, right_data
  );
endinterface

// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler
// Buffers stereo pairs from a valid/ready stream in a small FIFO and loads one pair into
// the I2S transmitter's left_data/right_data once per frame, on the sampled falling edge
// of lrclk. Counts underruns (saturating) and supports muting.
// Ports:
//   clk            system clock (shared with the transmitter)
//   nReset         synchronous active-low reset
//   bus            stream in, lrclk in, in_ready/left_data/right_data out
//   mute           force zero output at frame loads (samples still consumed)
//   frame_tick     one-cycle pulse per frame load
//   underrun       one-cycle pulse when a frame load finds the FIFO empty
//   underrun_count saturating underrun counter
//   level          FIFO occupancy
// Build option: define I2S_SCHED_HOLD_EN to repeat the previous pair on an unmuted
// underrun; otherwise underrun frames output zero.
module i2s_frame_scheduler #(
  parameter int unsigned WORD_SIZE  = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned UCNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        nReset,
  i2s_frame_scheduler_if.slave        bus,
  input  logic                        mute,
  output logic                        frame_tick,
  output logic                        underrun,
  output logic [UCNT_W-1:0]           underrun_count,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef logic [2*WORD_SIZE-1:0] pair_t;

  pair_t                mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 lrclk_q;
  logic [WORD_SIZE-1:0] left_q, left_d;
  logic [WORD_SIZE-1:0] right_q, right_d;
  logic                 tick_q, tick_d;
  logic                 under_q, under_d;
  logic [UCNT_W-1:0]    ucnt_q, ucnt_d;

  logic  push, pop, load, empty;
  pair_t head;

  assign bus.in_ready = (level_q < LW'(FIFO_DEPTH));
  assign empty        = (level_q == '0);
  assign push         = bus.in_valid & bus.in_ready;
  // Frame boundary: falling edge of lrclk as seen on clk.
  assign load         = lrclk_q & ~bus.lrclk;
  // A pair pushed on this edge is not visible yet: no empty-bypass.
  assign pop          = load & ~empty;
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    left_d   = left_q;
    right_d  = right_q;
    tick_d   = load;
    under_d  = load & empty;
    ucnt_d   = ucnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (load) begin
      if (!empty) begin
        if (mute) begin
          left_d  = '0;
          right_d = '0;
        end else begin
          left_d  = head[2*WORD_SIZE-1:WORD_SIZE];
          right_d = head[WORD_SIZE-1:0];
        end
      end else begin
        if (ucnt_q != '1) ucnt_d = ucnt_q + UCNT_W'(1);
        if (mute) begin
          left_d  = '0;
          right_d = '0;
        end else begin
`ifdef I2S_SCHED_HOLD_EN
          // Last-sample repeat: keep the previous pair.
          left_d  = left_q;
          right_d = right_q;
`else
          left_d  = '0;
          right_d = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      lrclk_q  <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      tick_q   <= 1'b0;
      under_q  <= 1'b0;
      ucnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      lrclk_q  <= bus.lrclk;
      left_q   <= left_d;
      right_q  <= right_d;
      tick_q   <= tick_d;
      under_q  <= under_d;
      ucnt_q   <= ucnt_d;
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_left, bus.in_right};
  end

  assign bus.left_data  = left_q;
  assign bus.right_data = right_q;
  assign frame_tick     = tick_q;
  assign underrun       = under_q;
  assign underrun_count = ucnt_q;
  assign level          = level_q;

endmodule
